pmic_sampler: RTL

- Upstream capture stage for the PMod MIC sample FIFO.
- Triggers conversions on the MIC's 12-bit SPI ADC at a programmable sample period.
- Deserialises each 16-bit ADC frame (4 leading zeros followed by 12 data bits, MSB first).
- Presents each sample as a one-cycle write strobe plus data, which wires directly to the FIFO write port (o_valid to i_wr, o_data to i_data).

---
 rtl/pmic_sampler.sv | 81 ++++++++
 1 files changed

// File: rtl/pmic_sampler.sv
// pmic_sampler: period-triggered SPI capture of 16-bit ADC frames into one-cycle sample strobes
module pmic_sampler #(
  parameter int CKPCK = 2,
  parameter int QUIET = 4,
  parameter int BW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [15:0]   i_period,
  input  logic          i_clr,
  output logic          o_csn,
  output logic          o_sck,
  input  logic          i_miso,
  output logic          o_valid,
  output logic [BW-1:0] o_data,
  output logic          o_zerr,
  output logic          o_late
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic        run;
  logic [7:0]  dcnt;
  logic [4:0]  half;
  logic [15:0] qcnt;
  logic [15:0] sreg;
  logic        trig, tick, done;
  assign trig = i_en && run && cnt == '0;
  assign tick = dcnt == '0;
  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else state <= state_n;
  end
  // next state; done marks the edge that ends the 16th high phase
  always_comb begin
    state_n = state;
    done = 1'b0;
    unique case (state)
      S_IDLE:  state_n = trig ? S_SETUP : S_IDLE;
      S_SETUP: state_n = tick ? S_SHIFT : S_SETUP;
      S_SHIFT: begin
        done = tick && o_sck && half == 5'd31;
        state_n = done ? S_QUIET : S_SHIFT;
      end
      S_QUIET: state_n = qcnt == '0 ? S_IDLE : S_QUIET;
      default: state_n = S_IDLE;
    endcase
  end
  // period counter, SCK divider, bit sequencing, capture and sticky flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      run <= 1'b0;
      dcnt <= '0;
      half <= '0;
      qcnt <= '0;
      sreg <= '0;
      o_csn <= 1'b1;
      o_sck <= 1'b1;
      o_valid <= 1'b0;
      o_data <= '0;
      o_zerr <= 1'b0;
      o_late <= 1'b0;
    end else begin
      run <= 1'b1;
      cnt <= (!i_en || !run || cnt == '0) ? i_period : cnt - 16'd1;
      dcnt <= (state != state_n || tick) ? 8'(CKPCK - 1) : dcnt - 8'd1;
      half <= state == S_SETUP ? 5'd0 : (state == S_SHIFT && tick) ? half + 5'd1 : half;
      qcnt <= done ? 16'(QUIET - 1) : state == S_QUIET ? qcnt - 16'd1 : qcnt;
      sreg <= (state == S_SHIFT && tick && !o_sck) ? {sreg[14:0], i_miso} : sreg;
      o_csn <= (state == S_IDLE && trig) ? 1'b0 : done ? 1'b1 : o_csn;
      o_sck <= (tick && (state == S_SETUP || (state == S_SHIFT && !done))) ? ~o_sck : o_sck;
      o_valid <= done;
      o_data <= done ? sreg[BW-1:0] : o_data;
      o_zerr <= (done && |sreg[15:BW]) || (o_zerr && !i_clr);
      o_late <= (trig && state != S_IDLE) || (o_late && !i_clr);
    end
  end
endmodule
